pipeline_debug_controller: RTL and testbench
============================================

PIPELINE_DEBUG_CONTROLLER -- requirements
Module: pipeline_debug_controller

Interface
REQ-001 SHALL have parameter INST_MEM_ADDR_WIDTH, default 9: instruction-memory byte-address width.
REQ-002 SHALL have parameter DATA_MEM_ADDR_WIDTH, default 8: data-memory byte-address width.
REQ-003 SHALL have port i_clk  input  1  single clock for the whole block.
REQ-004 SHALL have port i_reset  input  1  reset, synchronous, active-low.
REQ-005 SHALL have ports i_rx_data  input  8 and i_rx_valid  input  1: a received UART byte, with a one-cycle valid strobe.
REQ-006 SHALL have ports o_tx_data  output  8, o_tx_start  output  1 and i_tx_done  input  1: the byte to transmit, a one-cycle start pulse, and a one-cycle completion pulse from the transmitter.
REQ-007 SHALL have ports o_halt  output  1 and o_stall  output  1: pipeline freeze and stall controls.
REQ-008 SHALL have ports o_write_instruction_flag  output  1, o_instruction_to_write  output  32 and o_address_to_write_inst  output  INST_MEM_ADDR_WIDTH: the instruction-load port.
REQ-009 SHALL have ports i_IF_ID_latch  input  64, i_ID_EX_latch  input  139, i_EX_MEM_latch  input  76 and i_MEM_WB_latch  input  71: pipeline latch snapshots.
REQ-010 SHALL have ports o_reg_read  output  5 and i_reg_content  input  32: register-file readback.
REQ-011 SHALL have ports o_mem_addr  output  DATA_MEM_ADDR_WIDTH and i_mem_content  input  32: data-memory readback.
REQ-012 SHALL have port i_program_end  input  1: the pipeline has retired its HALT instruction.

Function
REQ-013 SHALL implement the FSM states IDLE, LOAD, LOAD_WRITE, RUN, STEP, DUMP_REG, DUMP_MEM, DUMP_LATCH and TX_WAIT.
REQ-014 In IDLE, on i_rx_valid, SHALL decode the command byte: 'L'(0x4C)->LOAD, 'C'(0x43)->RUN, 'S'(0x53)->STEP; any other byte SHALL be ignored.
REQ-015 LOAD: SHALL assemble 4 bytes, MSB first, into a 32-bit word, then go to LOAD_WRITE.
REQ-016 LOAD_WRITE: SHALL assert o_write_instruction_flag for exactly one cycle, with the current address and word, then add 4 to the address.
REQ-017 After writing the word 0xFFFFFFFF (HALT), SHALL return to IDLE and clear the load address to 0; any other word SHALL return to LOAD.
REQ-018 Load address overflow SHALL wrap modulo 2^INST_MEM_ADDR_WIDTH.
REQ-019 o_halt SHALL be 1 in every state except RUN and the single release cycle of STEP.
REQ-020 RUN: SHALL hold o_halt=0 until i_program_end=1, then enter DUMP_REG.
REQ-021 STEP: SHALL drive o_halt=0 for exactly one cycle, then enter DUMP_REG.
REQ-022 If i_program_end=1 on entry to RUN or STEP, SHALL not release o_halt and SHALL go directly to DUMP_REG.
REQ-023 Dump order SHALL be: registers 0..31 (4 bytes each), then data memory addresses 0,4,...,252 (4 bytes each), then latches IF_ID, ID_EX, EX_MEM, MEM_WB.
REQ-024 Each latch SHALL be zero-padded at the MSB to whole bytes (8, 18, 10 and 9 bytes), for a dump total of 429 bytes.
REQ-025 All words SHALL be sent MSB first.
REQ-026 SHALL change o_reg_read or o_mem_addr, wait one cycle, then capture the data into a 32-bit shift register.
REQ-027 Each byte SHALL be sent as one o_tx_start pulse; the next pulse SHALL NOT be issued before i_tx_done (TX_WAIT).
REQ-028 After the final byte's i_tx_done, SHALL return to IDLE.
REQ-029 i_rx_valid SHALL be ignored in all states other than IDLE and LOAD.
REQ-030 o_stall SHALL equal 0 at all times; it is reserved.

Reset
REQ-031 With i_reset=0 at a clock edge, SHALL go to IDLE, set o_halt=1, and set o_write_instruction_flag, o_tx_start, o_tx_data, o_instruction_to_write, o_address_to_write_inst, o_reg_read and o_mem_addr to 0, and clear all counters.
REQ-032 Reset mid-LOAD or mid-dump SHALL abort with no further write or tx pulses.

Structure
REQ-033 Command codes, the HALT sentinel, the byte counts (128/256/45) and the state encoding SHALL live in the shared package debug_pkg.
REQ-034 One sub-module, debug_tx_serializer (word/latch-to-byte shifter with tx handshake), SHALL be instantiated.

Verification
REQ-035 'L', then 0x20010005 and 0xFFFFFFFF -> two write pulses: addr 0 data 0x20010005; addr 4 data 0xFFFFFFFF; then IDLE.
REQ-036 'S' with i_program_end=0 -> o_halt low exactly 1 cycle; 429 tx pulses; the first 4 bytes equal reg0 content.
REQ-037 'C', i_program_end raised after 50 cycles -> o_halt low for 50 cycles, then 429 bytes; the last 9 bytes equal zero-padded MEM_WB.
REQ-038 i_tx_done withheld 100 cycles -> no second o_tx_start until done arrives.
REQ-039 Reset during byte 200 of a dump -> o_halt=1, IDLE, no further o_tx_start; a subsequent 'S' produces a full 429-byte dump.
REQ-040 Bytes 0x00 and 0x58 in IDLE -> no output activity.

Source files
------------

// File: rtl/debug_pkg.sv
// Shared definitions for the pipeline debug controller: UART command codes,
// the HALT sentinel, dump byte counts, latch widths, FSM state encoding and
// the payload handed from the controller to the byte serializer.
package debug_pkg;

    localparam logic [7:0]  CMD_LOAD  = 8'h4C;   // 'L'
    localparam logic [7:0]  CMD_RUN   = 8'h43;   // 'C'
    localparam logic [7:0]  CMD_STEP  = 8'h53;   // 'S'
    localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;

    localparam int unsigned REG_DUMP_BYTES   = 128;
    localparam int unsigned MEM_DUMP_BYTES   = 256;
    localparam int unsigned LATCH_DUMP_BYTES = 45;
    localparam int unsigned REG_WORDS        = REG_DUMP_BYTES / 4;
    localparam int unsigned MEM_WORDS        = MEM_DUMP_BYTES / 4;

    localparam int unsigned IF_ID_W  = 64;
    localparam int unsigned ID_EX_W  = 139;
    localparam int unsigned EX_MEM_W = 76;
    localparam int unsigned MEM_WB_W = 71;

    localparam int unsigned IF_ID_BYTES  = 8;
    localparam int unsigned ID_EX_BYTES  = 18;
    localparam int unsigned EX_MEM_BYTES = 10;
    localparam int unsigned MEM_WB_BYTES = 9;

    // Serializer holds the widest item (ID_EX) left-aligned.
    localparam int unsigned SER_W     = ID_EX_BYTES * 8;
    localparam int unsigned SER_CNT_W = 5;

    typedef enum logic [3:0] {
        ST_IDLE       = 4'd0,
        ST_LOAD       = 4'd1,
        ST_LOAD_WRITE = 4'd2,
        ST_RUN        = 4'd3,
        ST_STEP       = 4'd4,
        ST_DUMP_REG   = 4'd5,
        ST_DUMP_MEM   = 4'd6,
        ST_DUMP_LATCH = 4'd7,
        ST_TX_WAIT    = 4'd8
    } state_t;

    // One item to transmit: bytes taken MSB first from the top of data.
    typedef struct packed {
        logic [SER_W-1:0]     data;
        logic [SER_CNT_W-1:0] nbytes;
    } ser_req_t;

endpackage

// File: rtl/debug_tx_serializer.sv
// Byte serializer: takes a left-aligned item of 1..18 bytes and sends it MSB
// first, one tx_start pulse per byte, waiting for tx_done between bytes.
// Ports: clk_i, rst_n_i (sync, active-low), load_i/req_i (item to send),
// tx_done_i (transmitter completion), tx_data_o/tx_start_o (to transmitter),
// word_done_o (one-cycle pulse after the last byte's tx_done).
module debug_tx_serializer
    import debug_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       load_i,
    input  ser_req_t   req_i,
    input  logic       tx_done_i,
    output logic [7:0] tx_data_o,
    output logic       tx_start_o,
    output logic       word_done_o
);

    logic [SER_W-1:0]     shreg_q;
    logic [SER_CNT_W-1:0] left_q;
    logic                 waiting_q;
    logic                 tx_start_q;
    logic                 word_done_q;
    logic [7:0]           tx_data_q;

    // Shift out one byte per tx_done; left_q counts bytes still to start.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            shreg_q     <= '0;
            left_q      <= '0;
            waiting_q   <= 1'b0;
            tx_start_q  <= 1'b0;
            word_done_q <= 1'b0;
            tx_data_q   <= 8'h00;
        end else begin
            tx_start_q  <= 1'b0;
            word_done_q <= 1'b0;
            if (load_i) begin
                tx_data_q  <= req_i.data[SER_W-1 -: 8];
                shreg_q    <= req_i.data << 8;
                left_q     <= req_i.nbytes - SER_CNT_W'(1);
                tx_start_q <= 1'b1;
                waiting_q  <= 1'b1;
            end else if (waiting_q && tx_done_i) begin
                if (left_q == '0) begin
                    waiting_q   <= 1'b0;
                    word_done_q <= 1'b1;
                end else begin
                    tx_data_q  <= shreg_q[SER_W-1 -: 8];
                    shreg_q    <= shreg_q << 8;
                    left_q     <= left_q - SER_CNT_W'(1);
                    tx_start_q <= 1'b1;
                end
            end
        end
    end

    assign tx_data_o   = tx_data_q;
    assign tx_start_o  = tx_start_q;
    assign word_done_o = word_done_q;

endmodule

// File: rtl/pipeline_debug_controller.sv
// UART-driven debug controller for a 5-stage pipeline: loads instructions,
// runs or single-steps the core, then dumps registers, data memory and the
// four pipeline latches (429 bytes) through the UART transmitter.
// Ports: i_clk, i_reset (sync, active-low); i_rx_data/i_rx_valid (commands);
// o_tx_data/o_tx_start/i_tx_done (transmit handshake); o_halt/o_stall;
// o_write_instruction_flag/o_instruction_to_write/o_address_to_write_inst
// (instruction load); i_*_latch (latch snapshots); o_reg_read/i_reg_content
// and o_mem_addr/i_mem_content (readback); i_program_end (HALT retired).
module pipeline_debug_controller
    import debug_pkg::*;
#(
    parameter int unsigned INST_MEM_ADDR_WIDTH = 9,
    parameter int unsigned DATA_MEM_ADDR_WIDTH = 8
) (
    input  logic                           i_clk,
    input  logic                           i_reset,
    input  logic [7:0]                     i_rx_data,
    input  logic                           i_rx_valid,
    output logic [7:0]                     o_tx_data,
    output logic                           o_tx_start,
    input  logic                           i_tx_done,
    output logic                           o_halt,
    output logic                           o_stall,
    output logic                           o_write_instruction_flag,
    output logic [31:0]                    o_instruction_to_write,
    output logic [INST_MEM_ADDR_WIDTH-1:0] o_address_to_write_inst,
    input  logic [IF_ID_W-1:0]             i_IF_ID_latch,
    input  logic [ID_EX_W-1:0]             i_ID_EX_latch,
    input  logic [EX_MEM_W-1:0]            i_EX_MEM_latch,
    input  logic [MEM_WB_W-1:0]            i_MEM_WB_latch,
    output logic [4:0]                     o_reg_read,
    input  logic [31:0]                    i_reg_content,
    output logic [DATA_MEM_ADDR_WIDTH-1:0] o_mem_addr,
    input  logic [31:0]                    i_mem_content,
    input  logic                           i_program_end
);

    state_t                         state_q;
    state_t                         phase_q;
    logic [INST_MEM_ADDR_WIDTH-1:0] load_addr_q;
    logic [31:0]                    load_word_q;
    logic [1:0]                     byte_cnt_q;
    logic                           halt_q;
    logic                           wr_flag_q;
    logic [31:0]                    instr_q;
    logic [INST_MEM_ADDR_WIDTH-1:0] addr_inst_q;
    logic [4:0]                     reg_read_q;
    logic [DATA_MEM_ADDR_WIDTH-1:0] mem_addr_q;
    logic [5:0]                     word_idx_q;
    logic [1:0]                     latch_idx_q;
    logic                           settle_q;
    logic                           ser_load_q;
    ser_req_t                       ser_req_q;

    logic [5:0] word_idx_inc;
    ser_req_t   latch_req_c;
    logic       word_done;

    assign word_idx_inc = word_idx_q + 6'd1;

    // Latch payloads, zero-padded at the MSB to whole bytes, left-aligned.
    always_comb begin
        latch_req_c = '0;
        case (latch_idx_q)
            2'd0: latch_req_c = '{data: {i_IF_ID_latch, {(SER_W-IF_ID_BYTES*8){1'b0}}},
                                  nbytes: SER_CNT_W'(IF_ID_BYTES)};
            2'd1: latch_req_c = '{data: {{(ID_EX_BYTES*8-ID_EX_W){1'b0}}, i_ID_EX_latch},
                                  nbytes: SER_CNT_W'(ID_EX_BYTES)};
            2'd2: latch_req_c = '{data: {{(EX_MEM_BYTES*8-EX_MEM_W){1'b0}}, i_EX_MEM_latch,
                                         {(SER_W-EX_MEM_BYTES*8){1'b0}}},
                                  nbytes: SER_CNT_W'(EX_MEM_BYTES)};
            default: latch_req_c = '{data: {{(MEM_WB_BYTES*8-MEM_WB_W){1'b0}}, i_MEM_WB_latch,
                                            {(SER_W-MEM_WB_BYTES*8){1'b0}}},
                                     nbytes: SER_CNT_W'(MEM_WB_BYTES)};
        endcase
    end

    // Control FSM; every output comes straight from a register here.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            state_q     <= ST_IDLE;
            phase_q     <= ST_DUMP_REG;
            load_addr_q <= '0;
            load_word_q <= 32'h0;
            byte_cnt_q  <= 2'd0;
            halt_q      <= 1'b1;
            wr_flag_q   <= 1'b0;
            instr_q     <= 32'h0;
            addr_inst_q <= '0;
            reg_read_q  <= 5'd0;
            mem_addr_q  <= '0;
            word_idx_q  <= 6'd0;
            latch_idx_q <= 2'd0;
            settle_q    <= 1'b0;
            ser_load_q  <= 1'b0;
            ser_req_q   <= '0;
        end else begin
            wr_flag_q  <= 1'b0;
            ser_load_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    halt_q <= 1'b1;
                    if (i_rx_valid) begin
                        case (i_rx_data)
                            CMD_LOAD: begin
                                byte_cnt_q <= 2'd0;
                                state_q    <= ST_LOAD;
                            end
                            CMD_RUN, CMD_STEP: begin
                                word_idx_q  <= 6'd0;
                                reg_read_q  <= 5'd0;
                                mem_addr_q  <= '0;
                                latch_idx_q <= 2'd0;
                                settle_q    <= 1'b0;
                                // Program already finished: dump without releasing.
                                if (i_program_end) begin
                                    state_q <= ST_DUMP_REG;
                                end else begin
                                    halt_q  <= 1'b0;
                                    state_q <= (i_rx_data == CMD_RUN) ? ST_RUN : ST_STEP;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                ST_LOAD: begin
                    if (i_rx_valid) begin
                        load_word_q <= {load_word_q[23:0], i_rx_data};
                        byte_cnt_q  <= byte_cnt_q + 2'd1;
                        if (byte_cnt_q == 2'd3) begin
                            state_q <= ST_LOAD_WRITE;
                        end
                    end
                end
                ST_LOAD_WRITE: begin
                    wr_flag_q   <= 1'b1;
                    instr_q     <= load_word_q;
                    addr_inst_q <= load_addr_q;
                    if (load_word_q == HALT_WORD) begin
                        load_addr_q <= '0;
                        state_q     <= ST_IDLE;
                    end else begin
                        load_addr_q <= load_addr_q + INST_MEM_ADDR_WIDTH'(4);
                        state_q     <= ST_LOAD;
                    end
                end
                ST_RUN: begin
                    if (i_program_end) begin
                        halt_q  <= 1'b1;
                        state_q <= ST_DUMP_REG;
                    end
                end
                ST_STEP: begin
                    halt_q  <= 1'b1;
                    state_q <= ST_DUMP_REG;
                end
                // Address was set on entry; capture after one settle cycle.
                ST_DUMP_REG: begin
                    if (settle_q) begin
                        settle_q   <= 1'b0;
                        ser_load_q <= 1'b1;
                        ser_req_q  <= '{data: {i_reg_content, {(SER_W-32){1'b0}}},
                                       nbytes: SER_CNT_W'(4)};
                        phase_q    <= ST_DUMP_REG;
                        state_q    <= ST_TX_WAIT;
                    end else begin
                        settle_q <= 1'b1;
                    end
                end
                ST_DUMP_MEM: begin
                    if (settle_q) begin
                        settle_q   <= 1'b0;
                        ser_load_q <= 1'b1;
                        ser_req_q  <= '{data: {i_mem_content, {(SER_W-32){1'b0}}},
                                       nbytes: SER_CNT_W'(4)};
                        phase_q    <= ST_DUMP_MEM;
                        state_q    <= ST_TX_WAIT;
                    end else begin
                        settle_q <= 1'b1;
                    end
                end
                ST_DUMP_LATCH: begin
                    ser_load_q <= 1'b1;
                    ser_req_q  <= latch_req_c;
                    phase_q    <= ST_DUMP_LATCH;
                    state_q    <= ST_TX_WAIT;
                end
                ST_TX_WAIT: begin
                    if (word_done) begin
                        if (phase_q == ST_DUMP_REG) begin
                            if (word_idx_q == 6'(REG_WORDS - 1)) begin
                                word_idx_q <= 6'd0;
                                mem_addr_q <= '0;
                                state_q    <= ST_DUMP_MEM;
                            end else begin
                                word_idx_q <= word_idx_inc;
                                reg_read_q <= word_idx_inc[4:0];
                                state_q    <= ST_DUMP_REG;
                            end
                        end else if (phase_q == ST_DUMP_MEM) begin
                            if (word_idx_q == 6'(MEM_WORDS - 1)) begin
                                word_idx_q  <= 6'd0;
                                latch_idx_q <= 2'd0;
                                state_q     <= ST_DUMP_LATCH;
                            end else begin
                                word_idx_q <= word_idx_inc;
                                mem_addr_q <= DATA_MEM_ADDR_WIDTH'({word_idx_inc, 2'b00});
                                state_q    <= ST_DUMP_MEM;
                            end
                        end else begin
                            if (latch_idx_q == 2'd3) begin
                                latch_idx_q <= 2'd0;
                                reg_read_q  <= 5'd0;
                                mem_addr_q  <= '0;
                                state_q     <= ST_IDLE;
                            end else begin
                                latch_idx_q <= latch_idx_q + 2'd1;
                                state_q     <= ST_DUMP_LATCH;
                            end
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    debug_tx_serializer u_serializer (
        .clk_i       (i_clk),
        .rst_n_i     (i_reset),
        .load_i      (ser_load_q),
        .req_i       (ser_req_q),
        .tx_done_i   (i_tx_done),
        .tx_data_o   (o_tx_data),
        .tx_start_o  (o_tx_start),
        .word_done_o (word_done)
    );

    assign o_halt                   = halt_q;
    assign o_stall                  = 1'b0;
    assign o_write_instruction_flag = wr_flag_q;
    assign o_instruction_to_write   = instr_q;
    assign o_address_to_write_inst  = addr_inst_q;
    assign o_reg_read               = reg_read_q;
    assign o_mem_addr               = mem_addr_q;

endmodule

// File: tb/tb_pipeline_debug_controller.sv
// Self-checking bench for pipeline_debug_controller: randomized register,
// memory and latch contents, a transmitter responder with variable latency,
// and an expected 429-byte dump stream built directly from the dump rules.
module tb_pipeline_debug_controller;

    logic         i_clk;
    logic         i_reset;
    logic [7:0]   i_rx_data;
    logic         i_rx_valid;
    logic [7:0]   o_tx_data;
    logic         o_tx_start;
    logic         i_tx_done;
    logic         o_halt;
    logic         o_stall;
    logic         o_write_instruction_flag;
    logic [31:0]  o_instruction_to_write;
    logic [8:0]   o_address_to_write_inst;
    logic [63:0]  i_IF_ID_latch;
    logic [138:0] i_ID_EX_latch;
    logic [75:0]  i_EX_MEM_latch;
    logic [70:0]  i_MEM_WB_latch;
    logic [4:0]   o_reg_read;
    logic [31:0]  i_reg_content;
    logic [7:0]   o_mem_addr;
    logic [31:0]  i_mem_content;
    logic         i_program_end;

    pipeline_debug_controller #(
        .INST_MEM_ADDR_WIDTH (9),
        .DATA_MEM_ADDR_WIDTH (8)
    ) dut (
        .i_clk                    (i_clk),
        .i_reset                  (i_reset),
        .i_rx_data                (i_rx_data),
        .i_rx_valid               (i_rx_valid),
        .o_tx_data                (o_tx_data),
        .o_tx_start               (o_tx_start),
        .i_tx_done                (i_tx_done),
        .o_halt                   (o_halt),
        .o_stall                  (o_stall),
        .o_write_instruction_flag (o_write_instruction_flag),
        .o_instruction_to_write   (o_instruction_to_write),
        .o_address_to_write_inst  (o_address_to_write_inst),
        .i_IF_ID_latch            (i_IF_ID_latch),
        .i_ID_EX_latch            (i_ID_EX_latch),
        .i_EX_MEM_latch           (i_EX_MEM_latch),
        .i_MEM_WB_latch           (i_MEM_WB_latch),
        .o_reg_read               (o_reg_read),
        .i_reg_content            (i_reg_content),
        .o_mem_addr               (o_mem_addr),
        .i_mem_content            (i_mem_content),
        .i_program_end            (i_program_end)
    );

    localparam int DUMP_BYTES = 429;

    logic [31:0] reg_file [32];
    logic [31:0] mem_file [64];

    assign i_reg_content = reg_file[o_reg_read];
    assign i_mem_content = mem_file[o_mem_addr[7:2]];

    int tests_run;
    int tests_failed;
    int cyc;
    int tx_delay;       // 0 selects a random 1..4 cycle latency per byte
    int halt_low_cnt;
    int early_start;
    logic [7:0]  tx_bytes [$];
    int          start_cyc [$];
    int          wr_addr [$];
    logic [31:0] wr_data [$];
    logic [7:0]  exp_bytes [$];

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    always @(posedge i_clk) cyc <= cyc + 1;

    // Passive monitor: halt-low cycles and instruction write pulses.
    always @(negedge i_clk) begin
        if (!o_halt) halt_low_cnt <= halt_low_cnt + 1;
        if (o_write_instruction_flag) begin
            wr_addr.push_back(int'(o_address_to_write_inst));
            wr_data.push_back(o_instruction_to_write);
        end
    end

    // Transmitter model: records each byte and answers with a done pulse.
    initial begin : tx_responder
        bit outstanding;
        int wait_cnt;
        outstanding = 1'b0;
        wait_cnt    = 0;
        early_start = 0;
        i_tx_done   = 1'b0;
        forever begin
            @(negedge i_clk);
            i_tx_done = 1'b0;
            if (o_tx_start) begin
                tx_bytes.push_back(o_tx_data);
                start_cyc.push_back(cyc);
                if (outstanding) early_start = early_start + 1;
                outstanding = 1'b1;
                wait_cnt = (tx_delay == 0) ? int'($urandom_range(4, 1)) : tx_delay;
            end else if (outstanding) begin
                if (wait_cnt <= 1) begin
                    i_tx_done   = 1'b1;
                    outstanding = 1'b0;
                end else begin
                    wait_cnt = wait_cnt - 1;
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        @(negedge i_clk);
        i_rx_valid = 1'b1;
        i_rx_data  = b;
        @(negedge i_clk);
        i_rx_valid = 1'b0;
        repeat (3) @(negedge i_clk);
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int b = 3; b >= 0; b--) send_byte(w[8*b +: 8]);
    endtask

    task automatic randomize_sources();
        for (int i = 0; i < 32; i++) reg_file[i] = $urandom;
        for (int i = 0; i < 64; i++) mem_file[i] = $urandom;
        i_IF_ID_latch  = {$urandom, $urandom};
        i_ID_EX_latch  = 139'({$urandom, $urandom, $urandom, $urandom, $urandom});
        i_EX_MEM_latch = 76'({$urandom, $urandom, $urandom});
        i_MEM_WB_latch = 71'({$urandom, $urandom, $urandom});
    endtask

    // Reference dump: words MSB first, latches zero-extended to whole bytes.
    task automatic build_expected();
        logic [143:0] id_ex_p;
        logic [79:0]  ex_mem_p;
        logic [71:0]  mem_wb_p;
        exp_bytes.delete();
        for (int r = 0; r < 32; r++)
            for (int b = 3; b >= 0; b--) exp_bytes.push_back(reg_file[r][8*b +: 8]);
        for (int a = 0; a < 256; a += 4)
            for (int b = 3; b >= 0; b--) exp_bytes.push_back(mem_file[a/4][8*b +: 8]);
        id_ex_p  = 144'(i_ID_EX_latch);
        ex_mem_p = 80'(i_EX_MEM_latch);
        mem_wb_p = 72'(i_MEM_WB_latch);
        for (int b = 7;  b >= 0; b--) exp_bytes.push_back(i_IF_ID_latch[8*b +: 8]);
        for (int b = 17; b >= 0; b--) exp_bytes.push_back(id_ex_p[8*b +: 8]);
        for (int b = 9;  b >= 0; b--) exp_bytes.push_back(ex_mem_p[8*b +: 8]);
        for (int b = 8;  b >= 0; b--) exp_bytes.push_back(mem_wb_p[8*b +: 8]);
    endtask

    function automatic int stream_mismatches(input int base);
        int mm = 0;
        if (tx_bytes.size() - base < exp_bytes.size()) return exp_bytes.size();
        foreach (exp_bytes[k]) if (tx_bytes[base + k] !== exp_bytes[k]) mm++;
        return mm;
    endfunction

    task automatic wait_bytes(input int base, input int n, output bit ok);
        int budget = 20000;
        while ((tx_bytes.size() - base) < n && budget > 0) begin
            @(negedge i_clk);
            budget--;
        end
        ok = (tx_bytes.size() - base) >= n;
        repeat (30) @(negedge i_clk);
    endtask

    task automatic test_reset();
        i_reset = 1'b0;
        repeat (3) @(negedge i_clk);
        tests_run += 8;
        if (o_halt !== 1'b1) begin tests_failed++; $display("FAIL reset_halt got %b want 1", o_halt); end
        if (o_stall !== 1'b0) begin tests_failed++; $display("FAIL reset_stall got %b want 0", o_stall); end
        if (o_write_instruction_flag !== 1'b0) begin tests_failed++; $display("FAIL reset_wr_flag got %b want 0", o_write_instruction_flag); end
        if (o_tx_start !== 1'b0 || o_tx_data !== 8'h00) begin tests_failed++; $display("FAIL reset_tx got start=%b data=%h want 0/00", o_tx_start, o_tx_data); end
        if (o_instruction_to_write !== 32'h0) begin tests_failed++; $display("FAIL reset_instr got %h want 0", o_instruction_to_write); end
        if (o_address_to_write_inst !== 9'h0) begin tests_failed++; $display("FAIL reset_inst_addr got %h want 0", o_address_to_write_inst); end
        if (o_reg_read !== 5'd0) begin tests_failed++; $display("FAIL reset_reg_read got %0d want 0", o_reg_read); end
        if (o_mem_addr !== 8'd0) begin tests_failed++; $display("FAIL reset_mem_addr got %0d want 0", o_mem_addr); end
        i_reset = 1'b1;
        @(negedge i_clk);
    endtask

    task automatic test_idle_ignore();
        int tb0 = tx_bytes.size();
        int wb0 = wr_addr.size();
        int hb0 = halt_low_cnt;
        send_byte(8'h00);
        send_byte(8'h58);
        repeat (20) @(negedge i_clk);
        tests_run++;
        if (tx_bytes.size() != tb0 || wr_addr.size() != wb0 || halt_low_cnt != hb0 || o_halt !== 1'b1) begin
            tests_failed++;
            $display("FAIL idle_ignore got tx=%0d wr=%0d halt_low=%0d halt=%b want 0/0/0/1",
                     tx_bytes.size() - tb0, wr_addr.size() - wb0, halt_low_cnt - hb0, o_halt);
        end
    endtask

    task automatic test_load_basic();
        int wb0 = wr_addr.size();
        send_byte(8'h4C);
        send_word(32'h2001_0005);
        send_word(32'hFFFF_FFFF);
        repeat (5) @(negedge i_clk);
        tests_run++;
        if (wr_addr.size() - wb0 != 2) begin
            tests_failed++;
            $display("FAIL load_count got %0d want 2", wr_addr.size() - wb0);
        end else begin
            tests_run += 2;
            if (wr_addr[wb0] != 0 || wr_data[wb0] !== 32'h2001_0005) begin
                tests_failed++;
                $display("FAIL load_w0 got addr=%0d data=%h want 0/20010005", wr_addr[wb0], wr_data[wb0]);
            end
            if (wr_addr[wb0+1] != 4 || wr_data[wb0+1] !== 32'hFFFF_FFFF) begin
                tests_failed++;
                $display("FAIL load_w1 got addr=%0d data=%h want 4/ffffffff", wr_addr[wb0+1], wr_data[wb0+1]);
            end
        end
        tests_run++;
        if (o_halt !== 1'b1 || o_write_instruction_flag !== 1'b0) begin
            tests_failed++;
            $display("FAIL load_idle got halt=%b wr=%b want 1/0", o_halt, o_write_instruction_flag);
        end
    endtask

    // 130 words then HALT: address restarts at 0 and wraps at 512.
    task automatic test_load_wrap();
        logic [31:0] words [$];
        int wb0 = wr_addr.size();
        for (int i = 0; i < 130; i++) begin
            logic [31:0] w = $urandom;
            if (w == 32'hFFFF_FFFF) w = 32'h0;
            words.push_back(w);
        end
        words.push_back(32'hFFFF_FFFF);
        send_byte(8'h4C);
        foreach (words[i]) send_word(words[i]);
        repeat (5) @(negedge i_clk);
        tests_run++;
        if (wr_addr.size() - wb0 != words.size()) begin
            tests_failed++;
            $display("FAIL wrap_count got %0d want %0d", wr_addr.size() - wb0, words.size());
        end else begin
            foreach (words[i]) begin
                tests_run++;
                if (wr_addr[wb0+i] != (i * 4) % 512 || wr_data[wb0+i] !== words[i]) begin
                    tests_failed++;
                    $display("FAIL wrap_w%0d got addr=%0d data=%h want %0d/%h",
                             i, wr_addr[wb0+i], wr_data[wb0+i], (i * 4) % 512, words[i]);
                end
            end
        end
    endtask

    task automatic test_step();
        int tb0, hb0, eb0;
        bit ok;
        logic [31:0] first;
        randomize_sources();
        build_expected();
        tb0 = tx_bytes.size(); hb0 = halt_low_cnt; eb0 = early_start;
        send_byte(8'h53);
        wait_bytes(tb0, DUMP_BYTES, ok);
        tests_run += 5;
        if (!ok) begin tests_failed++; $display("FAIL step_timeout got %0d bytes want %0d", tx_bytes.size() - tb0, DUMP_BYTES); end
        if (tx_bytes.size() - tb0 != DUMP_BYTES) begin tests_failed++; $display("FAIL step_count got %0d want %0d", tx_bytes.size() - tb0, DUMP_BYTES); end
        if (halt_low_cnt - hb0 != 1) begin tests_failed++; $display("FAIL step_halt_low got %0d want 1", halt_low_cnt - hb0); end
        if (stream_mismatches(tb0) != 0) begin tests_failed++; $display("FAIL step_stream got %0d mismatching bytes want 0", stream_mismatches(tb0)); end
        if (early_start != eb0 || o_halt !== 1'b1) begin tests_failed++; $display("FAIL step_end got early=%0d halt=%b want 0/1", early_start - eb0, o_halt); end
        if (ok) begin
            first = {tx_bytes[tb0], tx_bytes[tb0+1], tx_bytes[tb0+2], tx_bytes[tb0+3]};
            tests_run++;
            if (first !== reg_file[0]) begin tests_failed++; $display("FAIL step_reg0 got %h want %h", first, reg_file[0]); end
        end
    endtask

    task automatic test_run();
        int tb0, hb0;
        bit ok;
        logic [71:0] mwb;
        randomize_sources();
        build_expected();
        tb0 = tx_bytes.size(); hb0 = halt_low_cnt;
        @(negedge i_clk);
        i_rx_valid = 1'b1;
        i_rx_data  = 8'h43;
        @(negedge i_clk);
        i_rx_valid = 1'b0;
        repeat (49) @(negedge i_clk);
        i_program_end = 1'b1;
        wait_bytes(tb0, DUMP_BYTES, ok);
        i_program_end = 1'b0;
        tests_run += 3;
        if (halt_low_cnt - hb0 != 50) begin tests_failed++; $display("FAIL run_halt_low got %0d want 50", halt_low_cnt - hb0); end
        if (tx_bytes.size() - tb0 != DUMP_BYTES) begin tests_failed++; $display("FAIL run_count got %0d want %0d", tx_bytes.size() - tb0, DUMP_BYTES); end
        if (stream_mismatches(tb0) != 0) begin tests_failed++; $display("FAIL run_stream got %0d mismatching bytes want 0", stream_mismatches(tb0)); end
        if (ok) begin
            mwb = {1'b0, i_MEM_WB_latch};
            for (int k = 0; k < 9; k++) begin
                tests_run++;
                if (tx_bytes[tb0 + DUMP_BYTES - 9 + k] !== mwb[71 - 8*k -: 8]) begin
                    tests_failed++;
                    $display("FAIL run_mem_wb_b%0d got %h want %h", k, tx_bytes[tb0 + DUMP_BYTES - 9 + k], mwb[71 - 8*k -: 8]);
                end
            end
        end
    endtask

    task automatic test_tx_backpressure();
        int tb0, sb0, eb0, budget;
        bit ok;
        randomize_sources();
        build_expected();
        tb0 = tx_bytes.size(); sb0 = start_cyc.size(); eb0 = early_start;
        tx_delay = 100;
        send_byte(8'h53);
        budget = 400;
        while (start_cyc.size() - sb0 < 2 && budget > 0) begin @(negedge i_clk); budget--; end
        tx_delay = 0;
        tests_run++;
        if (start_cyc.size() - sb0 < 2) begin
            tests_failed++;
            $display("FAIL bp_second_start got %0d starts want 2", start_cyc.size() - sb0);
        end else begin
            tests_run++;
            if (start_cyc[sb0+1] - start_cyc[sb0] < 100) begin
                tests_failed++;
                $display("FAIL bp_gap got %0d cycles want >=100", start_cyc[sb0+1] - start_cyc[sb0]);
            end
        end
        wait_bytes(tb0, DUMP_BYTES, ok);
        tests_run += 2;
        if (early_start != eb0) begin tests_failed++; $display("FAIL bp_early got %0d want 0", early_start - eb0); end
        if (stream_mismatches(tb0) != 0 || tx_bytes.size() - tb0 != DUMP_BYTES) begin
            tests_failed++;
            $display("FAIL bp_stream got %0d bytes %0d mismatching want %0d/0", tx_bytes.size() - tb0, stream_mismatches(tb0), DUMP_BYTES);
        end
    endtask

    task automatic test_reset_mid_dump();
        int tb0, wb0, hb0, budget;
        bit ok;
        randomize_sources();
        build_expected();
        tb0 = tx_bytes.size(); wb0 = wr_addr.size();
        send_byte(8'h53);
        budget = 5000;
        while (tx_bytes.size() - tb0 < 200 && budget > 0) begin @(negedge i_clk); budget--; end
        i_reset = 1'b0;
        repeat (2) @(negedge i_clk);
        tests_run++;
        if (o_halt !== 1'b1 || o_tx_start !== 1'b0) begin tests_failed++; $display("FAIL mid_reset_out got halt=%b start=%b want 1/0", o_halt, o_tx_start); end
        i_reset = 1'b1;
        repeat (60) @(negedge i_clk);
        tests_run++;
        if (tx_bytes.size() - tb0 != 200 || wr_addr.size() != wb0 || o_halt !== 1'b1) begin
            tests_failed++;
            $display("FAIL mid_reset_quiet got bytes=%0d wr=%0d halt=%b want 200/0/1", tx_bytes.size() - tb0, wr_addr.size() - wb0, o_halt);
        end
        tb0 = tx_bytes.size(); hb0 = halt_low_cnt;
        send_byte(8'h53);
        wait_bytes(tb0, DUMP_BYTES, ok);
        tests_run += 2;
        if (halt_low_cnt - hb0 != 1) begin tests_failed++; $display("FAIL post_reset_halt_low got %0d want 1", halt_low_cnt - hb0); end
        if (stream_mismatches(tb0) != 0 || tx_bytes.size() - tb0 != DUMP_BYTES) begin
            tests_failed++;
            $display("FAIL post_reset_stream got %0d bytes %0d mismatching want %0d/0", tx_bytes.size() - tb0, stream_mismatches(tb0), DUMP_BYTES);
        end
    endtask

    // Program already ended: both commands dump without ever releasing halt.
    task automatic test_program_end_on_entry();
        logic [7:0] cmds [2];
        int tb0, hb0;
        bit ok;
        cmds[0] = 8'h53;
        cmds[1] = 8'h43;
        i_program_end = 1'b1;
        for (int c = 0; c < 2; c++) begin
            randomize_sources();
            build_expected();
            tb0 = tx_bytes.size(); hb0 = halt_low_cnt;
            send_byte(cmds[c]);
            wait_bytes(tb0, DUMP_BYTES, ok);
            tests_run += 2;
            if (halt_low_cnt - hb0 != 0) begin tests_failed++; $display("FAIL end_entry_halt_%h got %0d low cycles want 0", cmds[c], halt_low_cnt - hb0); end
            if (stream_mismatches(tb0) != 0 || tx_bytes.size() - tb0 != DUMP_BYTES) begin
                tests_failed++;
                $display("FAIL end_entry_stream_%h got %0d bytes %0d mismatching want %0d/0", cmds[c], tx_bytes.size() - tb0, stream_mismatches(tb0), DUMP_BYTES);
            end
        end
        i_program_end = 1'b0;
    endtask

    initial begin
        tests_run      = 0;
        tests_failed   = 0;
        tx_delay       = 0;
        i_reset        = 1'b0;
        i_rx_valid     = 1'b0;
        i_rx_data      = 8'h00;
        i_program_end  = 1'b0;
        randomize_sources();
        test_reset();
        test_idle_ignore();
        test_load_basic();
        test_load_wrap();
        test_step();
        test_run();
        test_tx_backpressure();
        test_reset_mid_dump();
        test_program_end_on_entry();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial cyc = 0;
    initial halt_low_cnt = 0;

endmodule
